// File: rtl/sr_pkg.sv
// sr_pkg: shared width and FSM state type for the switch-register scanner
package sr_pkg;
  localparam int SR_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMPARE} sr_scan_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer (clk, reset_n async active-low, d async in, q synchronized out)
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sr_scan.sv
// sr_scan: scans a 74HC165 switch chain, debounces full scans, holds result (clk, reset_n, enable, sw_load_n, sw_sclk, sw_sdata, switches, scan_done)
module sr_scan
  import sr_pkg::*;
#(
  parameter int CLK_DIV        = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                sw_load_n,
  output logic                sw_sclk,
  input  logic                sw_sdata,
  output logic [SR_WIDTH-1:0] switches,
  output logic                scan_done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS);
  sr_scan_state_t state, state_nxt;
  logic [DW-1:0]       div;
  logic [3:0]          bit_idx;
  logic [SR_WIDTH-1:0] scan, prev;
  logic [MW-1:0]       match_cnt;
  logic                sdata_s, div_end, timed;
  sync2 u_sync (.clk(clk), .reset_n(reset_n), .d(sw_sdata), .q(sdata_s));
  assign div_end = div == DW'(CLK_DIV - 1);
  assign timed   = state == LOAD || state == SHIFT_LO || state == SHIFT_HI;
  always_comb begin
    state_nxt = state;
    sw_load_n = state != LOAD;
    sw_sclk   = state == SHIFT_HI;
    scan_done = state == COMPARE;
    case (state)
      IDLE:     state_nxt = enable ? LOAD : IDLE;
      LOAD:     state_nxt = div_end ? SHIFT_LO : LOAD;
      SHIFT_LO: state_nxt = div_end ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: state_nxt = !div_end ? SHIFT_HI : (bit_idx == 4'd0 ? COMPARE : SHIFT_LO);
      COMPARE:  state_nxt = enable ? LOAD : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      div       <= '0;
      bit_idx   <= 4'd15;
      scan      <= '0;
      prev      <= '0;
      match_cnt <= '0;
      switches  <= '0;
    end else begin
      state <= state_nxt;
      div   <= (timed && !div_end) ? div + 1'b1 : '0;
      if (state == LOAD) bit_idx <= 4'd15;
      else if (state == SHIFT_HI && div_end && bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
      // sample at the end of the low phase, well after the last rising sclk has settled through sync2
      if (state == SHIFT_LO && div_end) scan[bit_idx] <= sdata_s;
      if (state == COMPARE) begin
        if (scan == prev) begin
          if (match_cnt != MW'(DEBOUNCE_SCANS - 1)) match_cnt <= match_cnt + 1'b1;
          // this match brings (or keeps) the run at DEBOUNCE_SCANS identical scans
          if (match_cnt >= MW'(DEBOUNCE_SCANS - 2)) switches <= scan;
        end else begin
          prev      <= scan;
          match_cnt <= '0;
        end
      end
    end
endmodule
